fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Program-counter and instruction-fetch stage feeding decode. Consumes the jump/address redirect
//  produced by the jump decoder. Issues sequential fetches to a 1-cycle synchronous instruction
//  memory and holds fetched words in a 2-entry buffer, so decode stalls never drop a fetch.
//  Presents words to decode over a valid/ready handshake and flushes on a taken jump.
// PARAMETERS
//  ADDR_WIDTH  16      PC / memory address width
//  DATA_WIDTH  16      instruction width
//  RESET_PC    16'h0   first fetch address after reset
// PORTS
//  clk                in   1           rising-edge clock, sole clock
//  reset              in   1           asynchronous, active-high reset
//  imem_req           out  1           fetch request this cycle
//  imem_addr          out  ADDR_WIDTH  fetch address, valid with imem_req
//  imem_data          in   DATA_WIDTH  word for the request issued the previous cycle
//  instruction        out  DATA_WIDTH  buffer head to decode
//  instruction_pc     out  ADDR_WIDTH  address of instruction
//  instruction_valid  out  1           head entry valid
//  instruction_ready  in   1           decode accepts head this cycle
//  jump               in   1           taken jump for the head instruction (from jump decoder)
//  jump_address       in   ADDR_WIDTH  jump target; sampled only on jump acceptance
//  halted             out  1           fetch stopped by a self-jump
// BEHAVIOUR
//  Reset (async): state=IDLE; pc=RESET_PC; buffer empty; all outputs 0.
//  States:
//   IDLE  -> RUN after one cycle. No request is issued in IDLE.
//   RUN   -> request pc when slots_free > inflight; pc += 1 per request (wraps 16'hFFFF -> 0).
//   FLUSH -> one bubble cycle. No request, no valid. -> RUN.
//   HALT  -> terminal until reset. imem_req=0, instruction_valid=0, halted=1.
//  Fetch latency: a request at cycle N writes imem_data into the buffer at edge N+1. Earliest
//   instruction_valid is 2 cycles after the first RUN request.
//  Buffer: 2 entries, each holding {word, pc}. Requests are throttled so that
//   occupancy + inflight <= 2. Full buffer => imem_req=0. Never overwrite, never drop.
//  Handshake: transfer = instruction_valid & instruction_ready. The head pops on transfer.
//   instruction and instruction_pc stay stable while valid & !ready.
//  Simultaneous push+pop: both take effect. Occupancy is unchanged.
//  Jump: acts only when jump & transfer.
//   - Target == instruction_pc of the head: -> HALT, flush the buffer.
//   - Otherwise: pc=jump_address; buffer cleared; in-flight response discarded (tagged
//     invalid, not written); -> FLUSH.
//   - jump without a transfer is ignored.
//  Jump and push in the same cycle: flush wins; the arriving word is discarded.
//  Reset mid-operation: immediate return to the reset values; pending responses are ignored.
// CONFIGURATION
//  JUMP_COUNT_EN defined:
//   - adds output jump_count [15:0].
//   - Increments on each accepted non-halting jump; saturates at 16'hFFFF; resets to 0.
//  JUMP_COUNT_EN undefined:
//   - port absent; no counter logic.
// TESTING
//  1 Reset, ready=1, imem_data=addr+16'h100 -> decode sees 0x100,0x101,0x102 with pc 0,1,2;
//    one word per cycle after 2-cycle fill.
//  2 ready=0 for 5 cycles mid-stream -> imem_req drops once 2 buffered; no word lost/duplicated;
//    order preserved on release.
//  3 Head 0x103 (pc 3) accepted with jump=1, jump_address=0x20 -> 1 bubble; next valid
//    word pc=0x20; words from pc 4/5 never presented.
//  4 Head pc 0x20 accepted with jump=1, jump_address=0x20 -> halted=1 next cycle;
//    imem_req=0 and instruction_valid=0 thereafter.
//  5 Assert reset for 1 cycle with buffer full -> outputs 0 immediately;
//    restart fetch from RESET_PC.
//  6 JUMP_COUNT_EN: 3 jumps accepted + 1 jump with ready=0 -> jump_count=3.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port plus decode valid/ready handshake.
// master = fetch unit, slave = memory/decode side.
interface fetch_unit_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   logic                  imem_req;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0] imem_data;
   logic [DATA_WIDTH-1:0] instruction;
   logic [ADDR_WIDTH-1:0] instruction_pc;
   logic                  instruction_valid;
   logic                  instruction_ready;
   logic                  jump;
   logic [ADDR_WIDTH-1:0] jump_address;
   logic                  halted;

   modport master (
      output imem_req, imem_addr,
      input  imem_data,
      output instruction, instruction_pc, instruction_valid,
      input  instruction_ready,
      input  jump, jump_address,
      output halted
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_data,
      input  instruction, instruction_pc, instruction_valid,
      output instruction_ready,
      output jump, jump_address,
      input  halted
   );
endinterface

// File: rtl/fetch_unit.sv
// PC + fetch stage with a 2-entry buffer toward decode; flushes on taken jumps.
// Define JUMP_COUNT_EN to add a saturating jump_count output.
module fetch_unit #(
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    DATA_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic clk,
   input  logic reset,
   fetch_unit_if.master bus
`ifdef JUMP_COUNT_EN
   ,
   output logic [15:0] jump_count
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  inflight_q, inflight_d;
   logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
   logic [DATA_WIDTH-1:0] word_q [2];
   logic [DATA_WIDTH-1:0] word_d [2];
   logic [ADDR_WIDTH-1:0] wpc_q [2];
   logic [ADDR_WIDTH-1:0] wpc_d [2];
   logic [1:0]            count_q, count_d;

   logic       valid, pop, push, jump_take, self_jump, req;
   logic [1:0] free, idx;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ipc_d      = ipc_q;
      word_d     = word_q;
      wpc_d      = wpc_q;
      count_d    = count_q;
      req        = 1'b0;
      valid      = (count_q != 2'd0);
      pop        = valid & bus.instruction_ready;
      jump_take  = pop & bus.jump;
      self_jump  = jump_take & (bus.jump_address == wpc_q[0]);
      push       = inflight_q & ~jump_take;
      // a pop this cycle frees a slot in time for the next response
      free       = 2'd2 - count_q + {1'b0, pop};
      idx        = count_q - {1'b0, pop};

      unique case (state_q)
         IDLE:  state_d = RUN;
         RUN: begin
            if (jump_take) begin
               state_d = self_jump ? HALT : FLUSH;
               if (!self_jump) pc_d = bus.jump_address;
            end else if (free > {1'b0, inflight_q}) begin
               req   = 1'b1;
               pc_d  = pc_q + 1'b1;
               ipc_d = pc_q;
            end
         end
         FLUSH: state_d = RUN;
         HALT:  state_d = HALT;
         default: state_d = IDLE;
      endcase

      inflight_d = req;

      if (jump_take) begin
         count_d = 2'd0;
      end else begin
         if (pop) begin
            word_d[0] = word_q[1];
            wpc_d[0]  = wpc_q[1];
         end
         if (push) begin
            if (idx == 2'd0) begin
               word_d[0] = bus.imem_data;
               wpc_d[0]  = ipc_q;
            end else begin
               word_d[1] = bus.imem_data;
               wpc_d[1]  = ipc_q;
            end
         end
         count_d = count_q - {1'b0, pop} + {1'b0, push};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         inflight_q <= 1'b0;
         ipc_q      <= '0;
         word_q     <= '{default: '0};
         wpc_q      <= '{default: '0};
         count_q    <= 2'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         ipc_q      <= ipc_d;
         word_q     <= word_d;
         wpc_q      <= wpc_d;
         count_q    <= count_d;
      end
   end

   assign bus.imem_req          = req;
   assign bus.imem_addr         = pc_q;
   assign bus.instruction       = word_q[0];
   assign bus.instruction_pc    = wpc_q[0];
   assign bus.instruction_valid = valid;
   assign bus.halted            = (state_q == HALT);

`ifdef JUMP_COUNT_EN
   logic [15:0] jc_q, jc_d;

   always_comb begin
      jc_d = jc_q;
      if (jump_take && !self_jump && jc_q != 16'hFFFF) jc_d = jc_q + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) jc_q <= 16'd0;
      else       jc_q <= jc_d;
   end

   assign jump_count = jc_q;
`endif

endmodule
